// File: rtl/decod_pkg.sv
// Shared encodings for the one-hot decoder / scanner block.
package decod_pkg;

   // Operating mode as presented on the mode input
   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_PULSE  = 2'b01,
      MODE_SCAN   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   // Controller states; one per usable mode plus an idle/disabled state
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STATIC = 2'd1,
      ST_PULSE  = 2'd2,
      ST_SCAN   = 2'd3
   } state_e;

   // State selected at an edge: disable or the reserved mode park the block in IDLE
   function automatic state_e next_state(input logic en, input logic [1:0] mode);
      state_e st;
      st = ST_IDLE;
      if (en) begin
         case (mode_e'(mode))
            MODE_STATIC: st = ST_STATIC;
            MODE_PULSE:  st = ST_PULSE;
            MODE_SCAN:   st = ST_SCAN;
            default:     st = ST_IDLE;
         endcase
      end
      return st;
   endfunction

endpackage

// File: rtl/decod_onehot.sv
// Combinational W-to-2**W one-hot decoder.
module decod_onehot #(
   parameter int unsigned W = 3
) (
   input  logic [W-1:0]        idx_i,
   output logic [(2**W)-1:0]   onehot_o
);

   // Exactly one bit set, at position idx_i
   always_comb begin
      onehot_o        = '0;
      onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/decod_scan.sv
// One-hot decoder with static, single-pulse and dwell-timed scan modes.
module decod_scan
   import decod_pkg::*;
#(
   parameter int unsigned W     = 3,
   parameter int unsigned DWELL = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [W-1:0]        sel,
   input  logic                load,
   output logic [(2**W)-1:0]   d,
   output logic [W-1:0]        idx,
   output logic                wrap
);

   localparam int unsigned N        = 2**W;
   localparam int unsigned CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
   localparam logic [W-1:0]  IDX_LAST = W'(N - 1);

   state_e          state_q, state_d;
   logic [W-1:0]    idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   cnt_cur;
   logic [N-1:0]    d_q, d_d;
   logic            wrap_q, wrap_d;
   logic            load_prev_q;
   logic            load_rise;
   logic            d_on;
   logic [N-1:0]    onehot;

   // Decode of the index that will be registered this edge
   decod_onehot #(
      .W (W)
   ) u_onehot (
      .idx_i    (idx_d),
      .onehot_o (onehot)
   );

   // Next-state, dwell counter and output selection
   always_comb begin
      state_d   = next_state(en, mode);
      idx_d     = idx_q;
      cnt_d     = '0;
      wrap_d    = 1'b0;
      d_on      = 1'b0;
      load_rise = load & ~load_prev_q;
      // A scan entered from any other state always starts a fresh dwell
      cnt_cur   = (state_q == ST_SCAN) ? cnt_q : '0;

      case (state_d)
         ST_STATIC: begin
            idx_d = sel;
            d_on  = 1'b1;
         end
         ST_PULSE: begin
            if (load_rise) begin
               idx_d = sel;
               d_on  = 1'b1;
            end
         end
         ST_SCAN: begin
            d_on = 1'b1;
            if (load) begin
               // Load wins over any advance or wrap due this cycle
               idx_d = sel;
            end else if (cnt_cur == CNT_LAST) begin
               idx_d  = idx_q + W'(1);
               wrap_d = (idx_q == IDX_LAST);
            end else begin
               cnt_d = cnt_cur + CW'(1);
            end
         end
         default: begin
         end
      endcase

      d_d = d_on ? onehot : '0;
   end

   // State and output registers; previous-load tracks load in every state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         d_q         <= '0;
         wrap_q      <= 1'b0;
         load_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         d_q         <= d_d;
         wrap_q      <= wrap_d;
         load_prev_q <= load;
      end
   end

   assign d    = d_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_decod_scan.sv
// Directed bench for decod_scan: DWELL=4 and DWELL=1 instances share stimulus.
module tb_decod_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en, load;
   logic [1:0] mode;
   logic [2:0] sel;

   logic [7:0] d_a, d_b;
   logic [2:0] idx_a, idx_b;
   logic       wrap_a, wrap_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decod_scan #(.W(3), .DWELL(4)) u_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
      .d(d_a), .idx(idx_a), .wrap(wrap_a)
   );

   decod_scan #(.W(3), .DWELL(1)) u_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
      .d(d_b), .idx(idx_b), .wrap(wrap_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: per instance, index, cycles spent on it in scan, outputs
   int m_idx[2]  = '{0, 0};
   int m_run[2]  = '{0, 0};
   int m_d[2]    = '{0, 0};
   int m_wrap[2] = '{0, 0};
   int m_prev    = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; m_run[k] = 0; m_d[k] = 0; m_wrap[k] = 0;
         end
         m_prev = 0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 0;
            if (!en || mode == 2'b11) begin
               m_d[k] = 0;
               m_run[k] = 0;
            end else if (mode == 2'b00) begin
               m_idx[k] = int'(sel);
               m_d[k] = 1 << sel;
               m_run[k] = 0;
            end else if (mode == 2'b01) begin
               m_run[k] = 0;
               if (load && m_prev == 0) begin
                  m_idx[k] = int'(sel);
                  m_d[k] = 1 << sel;
               end else begin
                  m_d[k] = 0;
               end
            end else begin
               if (load) begin
                  m_idx[k] = int'(sel);
                  m_run[k] = 0;
               end else begin
                  m_run[k] = m_run[k] + 1;
                  if (m_run[k] == ((k == 0) ? 4 : 1)) begin
                     m_run[k] = 0;
                     m_wrap[k] = (m_idx[k] == 7) ? 1 : 0;
                     m_idx[k] = (m_idx[k] + 1) % 8;
                  end
               end
               m_d[k] = 1 << m_idx[k];
            end
         end
         m_prev = load ? 1 : 0;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("cmp_d_a",    int'(d_a),    m_d[0]);
      chk("cmp_idx_a",  int'(idx_a),  m_idx[0]);
      chk("cmp_wrap_a", int'(wrap_a), m_wrap[0]);
      chk("cmp_d_b",    int'(d_b),    m_d[1]);
      chk("cmp_idx_b",  int'(idx_b),  m_idx[1]);
      chk("cmp_wrap_b", int'(wrap_b), m_wrap[1]);
   end

   task automatic setin(input logic e, input logic [1:0] m, input logic [2:0] s, input logic l);
      en = e; mode = m; sel = s; load = l;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int scan_exp[8] = '{6, 6, 6, 7, 7, 7, 7, 0};

   initial begin
      setin(1'b0, 2'b00, 3'd0, 1'b0);
      #1 rst = 1'b1;
      repeat (2) tick();
      chk("rst_d",    int'(d_a),    0);
      chk("rst_idx",  int'(idx_a),  0);
      chk("rst_wrap", int'(wrap_a), 0);

      // Static decode, then disable
      rst = 1'b0;
      setin(1'b1, 2'b00, 3'd5, 1'b0);
      tick();
      chk("static_d",   int'(d_a),   8'b0010_0000);
      chk("static_idx", int'(idx_a), 5);
      setin(1'b0, 2'b00, 3'd5, 1'b0);
      tick();
      chk("disable_d",   int'(d_a),   0);
      chk("disable_idx", int'(idx_a), 5);

      // Pulse: held load gives one pulse; a new rising edge gives another
      setin(1'b1, 2'b01, 3'd2, 1'b1);
      tick();
      chk("pulse1_d",   int'(d_a),   8'b0000_0100);
      chk("pulse1_idx", int'(idx_a), 2);
      tick();
      chk("pulse_hold1_d", int'(d_a), 0);
      tick();
      chk("pulse_hold2_d", int'(d_a), 0);
      setin(1'b1, 2'b01, 3'd2, 1'b0);
      tick();
      chk("pulse_low_d", int'(d_a), 0);
      setin(1'b1, 2'b01, 3'd2, 1'b1);
      tick();
      chk("pulse2_d", int'(d_a), 8'b0000_0100);
      setin(1'b1, 2'b01, 3'd2, 1'b0);
      tick();
      chk("pulse2_end_d", int'(d_a), 0);

      // Scan from 6 with dwell 4, through the wrap
      setin(1'b1, 2'b10, 3'd6, 1'b1);
      tick();
      chk("scan_load_idx",  int'(idx_a),  6);
      chk("scan_load_d",    int'(d_a),    8'b0100_0000);
      chk("scan_load_wrap", int'(wrap_a), 0);
      setin(1'b1, 2'b10, 3'd6, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("scan_idx",  int'(idx_a),  scan_exp[i]);
         chk("scan_d",    int'(d_a),    1 << scan_exp[i]);
         chk("scan_wrap", int'(wrap_a), (i == 7) ? 1 : 0);
      end
      tick();
      chk("scan_post_wrap", int'(wrap_a), 0);

      // Dwell of one: index advances every cycle
      setin(1'b1, 2'b10, 3'd0, 1'b1);
      tick();
      chk("d1_load_idx",  int'(idx_b),  0);
      chk("d1_load_wrap", int'(wrap_b), 0);
      setin(1'b1, 2'b10, 3'd0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("d1_idx",  int'(idx_b),  i % 8);
         chk("d1_wrap", int'(wrap_b), (i == 8) ? 1 : 0);
      end
      repeat (7) tick();
      chk("d1_at7", int'(idx_b), 7);
      // Load while a wrap is due: load wins
      setin(1'b1, 2'b10, 3'd2, 1'b1);
      tick();
      chk("d1_override_idx",  int'(idx_b),  2);
      chk("d1_override_wrap", int'(wrap_b), 0);

      // Asynchronous reset mid-scan at index 3
      setin(1'b1, 2'b10, 3'd3, 1'b1);
      tick();
      setin(1'b1, 2'b10, 3'd3, 1'b0);
      tick();
      chk("pre_rst_idx", int'(idx_a), 3);
      rst = 1'b1;
      #1;
      chk("async_rst_d",   int'(d_a),   0);
      chk("async_rst_idx", int'(idx_a), 0);
      chk("async_rst_db",  int'(d_b),   0);
      tick();
      rst = 1'b0;
      setin(1'b1, 2'b10, 3'd5, 1'b0);
      tick();
      chk("post_rst_idx",   int'(idx_a), 0);
      chk("post_rst_d",     int'(d_a),   8'b0000_0001);
      chk("post_rst_idx_b", int'(idx_b), 1);
      repeat (3) tick();
      chk("post_rst_adv", int'(idx_a), 1);

      // Reserved mode, then disable with load in scan: outputs off, index held
      setin(1'b1, 2'b11, 3'd7, 1'b1);
      tick();
      chk("rsvd_d",    int'(d_a),    0);
      chk("rsvd_idx",  int'(idx_a),  1);
      chk("rsvd_wrap", int'(wrap_a), 0);
      setin(1'b0, 2'b10, 3'd4, 1'b1);
      tick();
      chk("en0_load_d",   int'(d_a),   0);
      chk("en0_load_idx", int'(idx_a), 1);
      // Resume scan without load: continues from index 1 with a fresh dwell
      setin(1'b1, 2'b10, 3'd4, 1'b0);
      tick();
      chk("resume_idx", int'(idx_a), 1);
      chk("resume_d",   int'(d_a),   8'b0000_0010);
      repeat (2) tick();
      chk("resume_hold", int'(idx_a), 1);
      tick();
      chk("resume_adv", int'(idx_a), 2);

      // Load held through a change into pulse mode produces no pulse
      setin(1'b1, 2'b00, 3'd3, 1'b1);
      tick();
      chk("held_static_d", int'(d_a), 8'b0000_1000);
      setin(1'b1, 2'b01, 3'd6, 1'b1);
      tick();
      chk("held_pulse_d",   int'(d_a),   0);
      chk("held_pulse_idx", int'(idx_a), 3);
      tick();
      chk("held_pulse_d2", int'(d_a), 0);
      setin(1'b1, 2'b01, 3'd6, 1'b0);
      tick();
      setin(1'b1, 2'b01, 3'd6, 1'b1);
      tick();
      chk("fresh_pulse_d",   int'(d_a),   8'b0100_0000);
      chk("fresh_pulse_idx", int'(idx_a), 6);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decod_scan.md
DECOD_SCAN -- requirements
Module: decod_scan

Interface
REQ-001 Parameter W, default 3: select width.
REQ-002 Parameter DWELL, default 4, legal range >= 1: clock cycles each output stays active in scan mode.
REQ-003 Derived constant N = 2**W: number of one-hot outputs.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 en  input  1: block enable.
REQ-007 mode  input  2: 00 STATIC, 01 PULSE, 10 SCAN, 11 reserved.
REQ-008 sel  input  W: select index.
REQ-009 load  input  1: pulse-trigger in PULSE mode; scan start-index load in SCAN mode.
REQ-010 d  output  N: registered one-hot decode, or all zero.
REQ-011 idx  output  W: index currently decoded; registered.
REQ-012 wrap  output  1: one-cycle flag when the scan index wraps from N-1 to 0.

Function
REQ-013 All outputs shall be registered; an input sampled at edge k affects d, idx and wrap after edge k.
REQ-014 FSM states: IDLE, STATIC, PULSE, SCAN. At every edge, en=0 or mode=11 selects IDLE; otherwise mode 00/01/10 selects STATIC/PULSE/SCAN.
REQ-015 IDLE: d=0 and wrap=0; the dwell counter is cleared; idx holds.
REQ-016 STATIC: every cycle, idx<=sel and d<=onehot(sel).
REQ-017 PULSE: a rising edge of load (load=1 with the previous sampled load=0) sets idx<=sel and d<=onehot(sel) for exactly one cycle; d=0 in all other PULSE cycles.
REQ-018 PULSE: load held high for M cycles produces exactly one pulse.
REQ-019 SCAN with load=1: idx<=sel, d<=onehot(sel), dwell counter cleared to 0.
REQ-020 SCAN with load=0: the dwell counter increments. When it reaches DWELL-1, it clears and idx<=(idx+1) mod N. d always equals onehot(idx) of the same cycle.
REQ-021 SCAN: wrap=1 for exactly the one cycle in which idx changes from N-1 to 0; wrap=0 in every other cycle and state.
REQ-022 With DWELL=1, idx advances every cycle.
REQ-023 Entering SCAN without load shall continue from the current idx, with the dwell counter starting at 0.
REQ-024 Simultaneous events: en=0 overrides load and mode. load in SCAN overrides a pending advance or wrap in the same cycle.
REQ-025 The previous-load register shall update every cycle in all states, so a load held through a mode change into PULSE produces no pulse.
REQ-026 The dwell counter shall be clog2(DWELL) bits wide (minimum 1) and shall never exceed DWELL-1.
REQ-027 Index arithmetic shall be W-bit modulo N; no out-of-range index can occur.

Reset
REQ-028 While rst=1, asynchronously: d=0, idx=0, wrap=0, dwell counter=0, previous-load register=0, state=IDLE.
REQ-029 Reset asserted mid-scan or mid-pulse shall abort the operation immediately, with no residual pulse after release.
REQ-030 The first edge after rst deasserts shall evaluate inputs normally, per REQ-014.

Structure
REQ-031 Package decod_pkg shall hold the mode encodings (STATIC, PULSE, SCAN, RSVD) and the FSM state enumeration.
REQ-032 One sub-module, decod_onehot (parameter W; combinational W-to-2**W one-hot), shall be instantiated once and fed from the next-index value.
REQ-033 decod_scan shall contain only the FSM, dwell counter, load edge detector and output registers.

Verification (W=3, DWELL=4 unless stated)
REQ-034 Reset then STATIC, en=1, sel=5 -> d=8'b00100000, idx=5 one cycle after sampling; en=0 -> d=0 on the next cycle.
REQ-035 PULSE, sel=2, load high for 3 cycles -> d=8'b00000100 for exactly 1 cycle, then 0; a second load rising edge produces a second pulse.
REQ-036 SCAN, load with sel=6, then load=0 -> idx 6,6,6,6,7,7,7,7,0; wrap=1 only in the first idx=0 cycle; d tracks onehot(idx).
REQ-037 SCAN with DWELL=1, load sel=0 -> idx 0..7 on consecutive cycles, wrap every 8th cycle.
REQ-038 rst asserted mid-scan at idx=3 -> d=0, idx=0 without waiting for a clock edge; after release in SCAN without load, scan restarts at idx=0.
REQ-039 mode=11, or en=0 together with load=1 in SCAN -> d=0, wrap=0, idx unchanged, dwell counter cleared.
